// File: rtl/uart_recv.sv
// uart_recv: 8E1 LSB-first UART receiver, mid-bit sampling realigned on each start edge.
module uart_recv #(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int BIT_TICKS  = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CW         = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] BIT_LD  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_TICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          p;
  logic          rx_m, rx_s, prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      p          <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      prev       <= 1'b1;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      prev  <= rx_s;
      valid <= 1'b0;
      // Only a high-to-low transition re-arms the receiver, so a line stuck low after a framing error is ignored
      if (state == IDLE) begin
        if (!rx_s && prev) begin
          cnt   <= HALF_LD;
          state <= START;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        case (state)
          START: begin
            cnt   <= BIT_LD;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end
          DATA: begin
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 3'd1;
            cnt   <= BIT_LD;
            state <= (idx == 3'd7) ? PARITY : DATA;
          end
          PARITY: begin
            p     <= rx_s;
            cnt   <= BIT_LD;
            state <= STOP;
          end
          STOP: begin
            data       <= shift;
            parity_err <= p != ^shift;
            frame_err  <= !rx_s;
            valid      <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
